// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the HI/LO multiply/divide sequencer.
package muldiv_ctrl_pkg;

    localparam int unsigned BITS  = 32;
    localparam int unsigned ACC_W = 2 * BITS;
    localparam int unsigned CNT_W = $clog2(BITS) + 1;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        SIGN = 2'b10,
        WB   = 2'b11
    } state_t;

    // Two's-complement negation at operand width.
    function automatic logic [BITS-1:0] negate(input logic [BITS-1:0] v);
        return ~v + BITS'(1);
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Iterative shift-add multiply / restoring divide sequencer producing one HI/LO write pulse.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [BITS-1:0] rs_data,
    input  logic [BITS-1:0] rt_data,
    output logic            busy,
    output logic            hi_write,
    output logic            lo_write,
    output logic [BITS-1:0] hi_data,
    output logic [BITS-1:0] lo_data,
    output logic            done
);

    state_t            state, state_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [BITS-1:0]   opnd, opnd_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              is_div, is_div_nxt;
    logic              sign_a, sign_a_nxt;
    logic              sign_b, sign_b_nxt;
    logic              div0, div0_nxt;
    logic              busy_q, busy_nxt;
    logic              wr_q, wr_nxt;
    logic [BITS-1:0]   hi_q, hi_nxt;
    logic [BITS-1:0]   lo_q, lo_nxt;

    logic              op_signed;
    logic              op_div;
    logic              sa, sb;
    logic [BITS-1:0]   mag_a, mag_b;
    logic [BITS:0]     mul_sum;
    logic [BITS:0]     rem_sh;
    logic [BITS:0]     div_diff;
    logic [ACC_W-1:0]  prod_neg;
    logic [BITS-1:0]   acc_hi, acc_lo;

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        opnd_nxt   = opnd;
        cnt_nxt    = cnt;
        is_div_nxt = is_div;
        sign_a_nxt = sign_a;
        sign_b_nxt = sign_b;
        div0_nxt   = div0;
        busy_nxt   = busy_q;
        wr_nxt     = 1'b0;
        hi_nxt     = hi_q;
        lo_nxt     = lo_q;

        op_signed = (op == OP_MULT) || (op == OP_DIV);
        op_div    = (op == OP_DIV) || (op == OP_DIVU);
        sa        = op_signed & rs_data[BITS-1];
        sb        = op_signed & rt_data[BITS-1];
        mag_a     = sa ? negate(rs_data) : rs_data;
        mag_b     = sb ? negate(rt_data) : rt_data;

        acc_hi    = acc[ACC_W-1:BITS];
        acc_lo    = acc[BITS-1:0];
        mul_sum   = {1'b0, acc_hi} + {1'b0, opnd};
        rem_sh    = acc[ACC_W-1:BITS-1];
        div_diff  = rem_sh - {1'b0, opnd};
        prod_neg  = ~acc + ACC_W'(1);

        unique case (state)
            IDLE: begin
                if (start) begin
                    is_div_nxt = op_div;
                    sign_a_nxt = sa;
                    sign_b_nxt = sb;
                    div0_nxt   = op_div & (rt_data == '0);
                    // Multiply: multiplier in the low half, multiplicand in opnd.
                    // Divide: dividend in the low half (quotient side), divisor in opnd.
                    acc_nxt    = op_div ? {BITS'(0), mag_a} : {BITS'(0), mag_b};
                    opnd_nxt   = op_div ? mag_b : mag_a;
                    cnt_nxt    = CNT_W'(BITS);
                    busy_nxt   = 1'b1;
                    state_nxt  = CALC;
                end
            end
            CALC: begin
                if (is_div) begin
                    acc_nxt = div_diff[BITS] ? {rem_sh[BITS-1:0], acc[BITS-2:0], 1'b0}
                                             : {div_diff[BITS-1:0], acc[BITS-2:0], 1'b1};
                end else begin
                    acc_nxt = acc[0] ? {mul_sum, acc[BITS-1:1]}
                                     : {1'b0, acc[ACC_W-1:1]};
                end
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = SIGN;
                end
            end
            SIGN: begin
                if (is_div && div0) begin
                    // Remainder holds |rs|; undoing the magnitude step returns rs unchanged.
                    lo_nxt = '1;
                    hi_nxt = sign_a ? negate(acc_hi) : acc_hi;
                end else if (is_div) begin
                    lo_nxt = (sign_a ^ sign_b) ? negate(acc_lo) : acc_lo;
                    hi_nxt = sign_a ? negate(acc_hi) : acc_hi;
                end else begin
                    {hi_nxt, lo_nxt} = (sign_a ^ sign_b) ? prod_neg : acc;
                end
                wr_nxt    = 1'b1;
                state_nxt = WB;
            end
            WB: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            div0   <= 1'b0;
            busy_q <= 1'b0;
            wr_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            opnd   <= opnd_nxt;
            cnt    <= cnt_nxt;
            is_div <= is_div_nxt;
            sign_a <= sign_a_nxt;
            sign_b <= sign_b_nxt;
            div0   <= div0_nxt;
            busy_q <= busy_nxt;
            wr_q   <= wr_nxt;
            hi_q   <= hi_nxt;
            lo_q   <= lo_nxt;
        end
    end

    assign busy     = busy_q;
    assign hi_write = wr_q;
    assign lo_write = wr_q;
    assign done     = wr_q;
    assign hi_data  = hi_q;
    assign lo_data  = lo_q;

endmodule
